fir_da_scheduler: RTL

- Sequences the distributed-arithmetic FIR engine for streaming use.
- Accepts one input sample per transaction over a valid/ready handshake and shifts it into a TAPS-deep sample delay line.
- Launches one engine computation per sample, guards the engine with a watchdog, and presents each filter result on a valid/ready output stream.
- Sits between the sample source/sink and the DA engine; coefficient memory stays owned by the engine.

---
 rtl/fir_pkg.sv | 28 ++
 rtl/fir_da_scheduler_if.sv | 23 ++
 rtl/fir_sample_delay_line.sv | 35 +++
 rtl/fir_da_scheduler.sv | 114 +++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared defaults, state encoding and width helpers for the DA FIR scheduler.
// Imported by the scheduler top and the sample delay line.
package fir_pkg;

  localparam int TAPS           = 128;
  localparam int DATA_WIDTH     = 16;
  localparam int INTERNAL_WIDTH = 24;
  localparam int TIMEOUT_CYCLES = 16384;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    DRAIN  = 2'd3
  } sched_state_t;

  function automatic int fill_w(input int taps);
    return $clog2(taps + 1);
  endfunction

  function automatic int wd_w(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

  localparam int FILL_W_DEF = fill_w(TAPS);
  localparam int WD_W_DEF   = wd_w(TIMEOUT_CYCLES);

endpackage

// File: rtl/fir_da_scheduler_if.sv
// Sample-in / result-out valid-ready streams of the DA FIR scheduler.
// master: sample source + result sink; slave: the scheduler.
interface fir_da_scheduler_if #(
  parameter int DATA_WIDTH     = 16,
  parameter int INTERNAL_WIDTH = 24
);
  logic [DATA_WIDTH-1:0]     s_data;
  logic                      s_valid;
  logic                      s_ready;
  logic [INTERNAL_WIDTH-1:0] m_data;
  logic                      m_valid;
  logic                      m_ready;

  modport master (
    output s_data, s_valid, m_ready,
    input  s_ready, m_data, m_valid
  );

  modport slave (
    input  s_data, s_valid, m_ready,
    output s_ready, m_data, m_valid
  );
endinterface

// File: rtl/fir_sample_delay_line.sv
// TAPS-deep sample shift register; slice 0 newest, flattened bus out.
// Ports: clk, rst_n, shift_en, flush, din, samples, fill_level.
module fir_sample_delay_line
  import fir_pkg::*;
#(
  parameter int TAPS       = fir_pkg::TAPS,
  parameter int DATA_WIDTH = fir_pkg::DATA_WIDTH,
  localparam int FW        = fill_w(TAPS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       shift_en,
  input  logic                       flush,
  input  logic [DATA_WIDTH-1:0]      din,
  output logic [TAPS*DATA_WIDTH-1:0] samples,
  output logic [FW-1:0]              fill_level
);

  localparam int LOW = (TAPS - 1) * DATA_WIDTH;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samples    <= '0;
      fill_level <= '0;
    end else if (flush) begin
      samples    <= '0;
      fill_level <= '0;
    end else if (shift_en) begin
      samples <= {samples[LOW-1:0], din};
      if (fill_level != FW'(TAPS))
        fill_level <= fill_level + FW'(1);
    end
  end

endmodule

// File: rtl/fir_da_scheduler.sv
// Streams samples into the delay line, launches the DA engine per sample,
// watchdogs it and holds each result on the output stream until taken.
module fir_da_scheduler
  import fir_pkg::*;
#(
  parameter int TAPS           = fir_pkg::TAPS,
  parameter int DATA_WIDTH     = fir_pkg::DATA_WIDTH,
  parameter int INTERNAL_WIDTH = fir_pkg::INTERNAL_WIDTH,
  parameter int TIMEOUT_CYCLES = fir_pkg::TIMEOUT_CYCLES,
  localparam int FW            = fill_w(TAPS),
  localparam int WW            = wd_w(TIMEOUT_CYCLES)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  fir_da_scheduler_if.slave          io,
  input  logic                       flush,
  output logic                       da_start,
  output logic                       da_data_valid,
  output logic [TAPS*DATA_WIDTH-1:0] da_samples,
  input  logic [INTERNAL_WIDTH-1:0]  da_result,
  input  logic                       da_result_valid,
  output logic                       busy,
  output logic [FW-1:0]              fill_level,
  output logic                       timeout_err
);

  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);

  sched_state_t              state;
  logic [WW-1:0]             wd;
  logic                      pend;
  logic [INTERNAL_WIDTH-1:0] m_data_q;
  logic                      m_valid_q;
  logic                      idle;
  logic                      take;
  logic                      line_flush;

  assign idle       = (state == IDLE);
  assign io.s_ready = idle && !flush && !pend;
  assign take       = io.s_valid && io.s_ready;
  // A flush seen while busy is replayed on the first IDLE cycle.
  assign line_flush = idle && (flush || pend);
  assign busy       = !idle;
  assign io.m_data  = m_data_q;
  assign io.m_valid = m_valid_q;

  fir_sample_delay_line #(
    .TAPS       (TAPS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_line (
    .clk        (clk),
    .rst_n      (rst_n),
    .shift_en   (take),
    .flush      (line_flush),
    .din        (io.s_data),
    .samples    (da_samples),
    .fill_level (fill_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      wd            <= '0;
      pend          <= 1'b0;
      m_data_q      <= '0;
      m_valid_q     <= 1'b0;
      da_start      <= 1'b0;
      da_data_valid <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      da_start      <= 1'b0;
      da_data_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (take) begin
            da_start      <= 1'b1;
            da_data_valid <= 1'b1;
            state         <= LAUNCH;
          end
        end
        LAUNCH: begin
          wd    <= '0;
          state <= WAIT;
        end
        WAIT: begin
          wd <= wd + WW'(1);
          // A result on the expiry cycle still wins.
          if (da_result_valid) begin
            m_data_q  <= da_result;
            m_valid_q <= 1'b1;
            state     <= DRAIN;
          end else if (wd == WD_LAST) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end
        end
        DRAIN: begin
          if (io.m_ready) begin
            m_valid_q <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (!idle && flush)
        pend <= 1'b1;
      if (line_flush) begin
        pend        <= 1'b0;
        timeout_err <= 1'b0;
      end
    end
  end

endmodule
